// File: rtl/odu_pkg.sv
// Shared definitions for the ODU payload path: payload word layout, channel types,
// FSM encoding and the ODU rate ratios also used by odu_count_reg.
package odu_pkg;

    localparam int TYPE_BIT = 31;
    localparam int FCNT_MSB = 30;
    localparam int FCNT_LSB = 24;
    localparam int WIDX_MSB = 23;
    localparam int WIDX_LSB = 16;
    localparam int SEQ_MSB  = 15;
    localparam int SEQ_LSB  = 0;

    localparam int FCNT_W = FCNT_MSB - FCNT_LSB + 1;
    localparam int WIDX_W = WIDX_MSB - WIDX_LSB + 1;
    localparam int SEQ_W  = SEQ_MSB - SEQ_LSB + 1;

    localparam logic CHID_TYPE0 = 1'b0;
    localparam logic CHID_TYPE2 = 1'b1;

    localparam int RATE_T0_NUM = 9;
    localparam int RATE_T0_DEN = 74984;
    localparam int RATE_T2_NUM = 7;
    localparam int RATE_T2_DEN = 9373;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } odu_state_t;

    typedef struct packed {
        logic        sof;
        logic        eof;
        logic [31:0] data;
    } odu_entry_t;

    function automatic logic [31:0] odu_pack_word(
        input logic              typeBit,
        input logic [FCNT_W-1:0] frameCnt,
        input logic [WIDX_W-1:0] wordIdx,
        input logic [SEQ_W-1:0]  seqCnt
    );
        logic [31:0] word;
        word                    = '0;
        word[TYPE_BIT]          = typeBit;
        word[FCNT_MSB:FCNT_LSB] = frameCnt;
        word[WIDX_MSB:WIDX_LSB] = wordIdx;
        word[SEQ_MSB:SEQ_LSB]   = seqCnt;
        return word;
    endfunction

    // Rate ratio of a channel type, shared with the upstream rate counter.
    function automatic int odu_rate_num(input logic chidType);
        return (chidType == CHID_TYPE0) ? RATE_T0_NUM : RATE_T2_NUM;
    endfunction

    function automatic int odu_rate_den(input logic chidType);
        return (chidType == CHID_TYPE2) ? RATE_T2_DEN : RATE_T0_DEN;
    endfunction

endpackage

// File: rtl/odu_sync_fifo.sv
// Small synchronous FIFO of payload entries; head is read straight from the
// storage registers and forced to zero while empty.
module odu_sync_fifo
    import odu_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  odu_entry_t       i_entry,
    output logic             o_full,
    output logic             o_empty,
    output logic [LVL_W-1:0] o_level,
    output odu_entry_t       o_head
);

    localparam int AW = $clog2(DEPTH);

    odu_entry_t       r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [LVL_W-1:0] r_level;

    logic w_pop;
    logic w_push;

    assign o_full  = (r_level == LVL_W'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_head  = o_empty ? '0 : r_mem[r_rdPtr];

    // A push into a full FIFO is only legal when the head leaves on the same edge.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= i_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/odu_payload_gen.sv
// Builds one tagged 32-bit ODU payload word per rate strobe and streams the
// buffered words to the framer over valid/ready, flagging dropped words.
module odu_payload_gen
    import odu_pkg::*;
#(
    parameter  int FIFO_DEPTH  = 8,
    parameter  int FRAME_WORDS = 16,
    localparam int LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_chid,
    input  logic             chid_type,
    input  logic             enable_gen_data,
    output logic [31:0]      data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             sof,
    output logic             eof,
    output logic             frame_abort,
    output logic             overflow,
    input  logic             clr_overflow,
    output logic [LVL_W-1:0] fifo_level
);

    odu_state_t        r_state;
    logic [WIDX_W-1:0] r_wordIdx;
    logic [FCNT_W-1:0] r_frameCnt;
    logic [SEQ_W-1:0]  r_seqCnt;
    logic              r_typeLat;
    logic              r_frameAbort;
    logic              r_overflow;

    logic       w_gen;
    logic       w_firstWord;
    logic       w_lastWord;
    logic       w_typeBit;
    logic       w_pop;
    logic       w_push;
    logic       w_full;
    logic       w_empty;
    odu_entry_t w_entry;
    odu_entry_t w_head;

    assign w_gen       = (r_state == ACTIVE) && enable_chid && enable_gen_data;
    assign w_firstWord = (r_wordIdx == '0);
    assign w_lastWord  = (r_wordIdx == WIDX_W'(FRAME_WORDS - 1));
    // Word 0 carries the live channel type; later words use the latched one.
    assign w_typeBit   = w_firstWord ? chid_type : r_typeLat;

    assign w_entry.sof  = w_firstWord;
    assign w_entry.eof  = w_lastWord;
    assign w_entry.data = odu_pack_word(w_typeBit, r_frameCnt, r_wordIdx, r_seqCnt);

    assign w_pop  = !w_empty && data_ready;
    assign w_push = w_gen && (!w_full || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_wordIdx    <= '0;
            r_frameCnt   <= '0;
            r_seqCnt     <= '0;
            r_typeLat    <= 1'b0;
            r_frameAbort <= 1'b0;
        end else begin
            r_frameAbort <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (enable_chid) begin
                        r_state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (!enable_chid) begin
                        r_state <= IDLE;
                        // A partially sent frame is closed out so the next one starts clean.
                        if (!w_firstWord) begin
                            r_frameAbort <= 1'b1;
                            r_wordIdx    <= '0;
                            r_frameCnt   <= r_frameCnt + 1'b1;
                        end
                    end else if (enable_gen_data) begin
                        r_seqCnt <= r_seqCnt + 1'b1;
                        if (w_firstWord) begin
                            r_typeLat <= chid_type;
                        end
                        if (w_lastWord) begin
                            r_wordIdx  <= '0;
                            r_frameCnt <= r_frameCnt + 1'b1;
                        end else begin
                            r_wordIdx <= r_wordIdx + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Sticky drop flag; a new drop beats a clear on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_gen && !w_push) begin
            r_overflow <= 1'b1;
        end else if (clr_overflow) begin
            r_overflow <= 1'b0;
        end
    end

    odu_sync_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_entry (w_entry),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level),
        .o_head  (w_head)
    );

    assign data_valid  = !w_empty;
    assign data_out    = w_head.data;
    assign sof         = w_head.sof;
    assign eof         = w_head.eof;
    assign frame_abort = r_frameAbort;
    assign overflow    = r_overflow;

endmodule
